// File: rtl/ip_hdr_chksum_tx.sv
// ip_hdr_chksum_tx
// Transmit-side header finisher that sits between the TCP engine and the
// packet assembler. It takes one {IPv4 header, TCP header, payload
// descriptor} at a time. It computes the IPv4 header checksum serially, one
// 16-bit word per cycle, and writes the result into the header. It then
// presents the finished set to the assembler.
//
// Optional feature macro: TCP_PSEUDO_CSUM_EN
//   When defined, the block also sums the TCP pseudo-header and the TCP
//   header words. It outputs the folded, uncomplemented partial sum on
//   chksum_parser_tx_tcp_partial.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   tcp_chksum_tx_val/_rdy         upstream handshake (header set in)
//   tcp_chksum_tx_ip_header        IPv4 header, checksum field ignored
//   tcp_chksum_tx_tcp_header       TCP header
//   tcp_chksum_tx_payload_addr/len payload descriptor
//   chksum_parser_tx_val/_rdy      downstream handshake (header set out)
//   chksum_parser_tx_ip_header     IPv4 header with checksum filled in
//   chksum_parser_tx_tcp_header    registered TCP header
//   chksum_parser_tx_payload_*     registered payload descriptor
//   chksum_parser_tx_tcp_partial   TCP partial sum (TCP_PSEUDO_CSUM_EN only)

`ifndef IP_HEADER_WIDTH
`define IP_HEADER_WIDTH 160
`endif
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif
`ifndef PAYLOAD_BUF_ENTRY_ADDR_WIDTH
`define PAYLOAD_BUF_ENTRY_ADDR_WIDTH 32
`endif
`ifndef PAYLOAD_BUF_ENTRY_LEN_WIDTH
`define PAYLOAD_BUF_ENTRY_LEN_WIDTH 16
`endif
`ifndef IP_HEADER_BYTES
`define IP_HEADER_BYTES 20
`endif

module ip_hdr_chksum_tx (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     tcp_chksum_tx_val,
   output logic                                     chksum_tcp_tx_rdy,
   input  logic [`IP_HEADER_WIDTH-1:0]              tcp_chksum_tx_ip_header,
   input  logic [`TCP_HEADER_WIDTH-1:0]             tcp_chksum_tx_tcp_header,
   input  logic [`PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0] tcp_chksum_tx_payload_addr,
   input  logic [`PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]  tcp_chksum_tx_payload_len,
   output logic                                     chksum_parser_tx_val,
   input  logic                                     parser_chksum_tx_rdy,
   output logic [`IP_HEADER_WIDTH-1:0]              chksum_parser_tx_ip_header,
   output logic [`TCP_HEADER_WIDTH-1:0]             chksum_parser_tx_tcp_header,
   output logic [`PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0] chksum_parser_tx_payload_addr,
   output logic [`PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]  chksum_parser_tx_payload_len
`ifdef TCP_PSEUDO_CSUM_EN
  ,output logic [15:0]                              chksum_parser_tx_tcp_partial
`endif
);

   localparam int IP_W   = `IP_HEADER_WIDTH;
   localparam int TCP_W  = `TCP_HEADER_WIDTH;
   localparam int ADDR_W = `PAYLOAD_BUF_ENTRY_ADDR_WIDTH;
   localparam int LEN_W  = `PAYLOAD_BUF_ENTRY_LEN_WIDTH;
   localparam int N_IP   = IP_W / 16;
   localparam int N_TCP  = TCP_W / 16;
`ifdef TCP_PSEUDO_CSUM_EN
   localparam int N_SUM  = (N_IP > N_TCP) ? N_IP : N_TCP;
`else
   localparam int N_SUM  = N_IP;
`endif
   localparam int CNT_W  = (N_SUM > 1) ? $clog2(N_SUM) : 1;
   // LSB of IPv4 word 5 (header checksum field)
   localparam int IP_CSUM_LSB = IP_W - 96;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SUM  = 2'd1,
      S_FOLD = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   // Word idx of an IP header, MSB-first; indices past the end read as 0
   // because the shift pushes every header bit out.
   function automatic logic [15:0] ip_word(input logic [IP_W-1:0] hdr,
                                           input logic [CNT_W-1:0] idx);
      logic [IP_W-1:0] sh;
      sh = hdr << {idx, 4'b0000};
      return sh[IP_W-1 -: 16];
   endfunction

   // One's-complement fold of a 32-bit sum; the second add absorbs the
   // carry that the first add can produce.
   function automatic logic [15:0] fold16(input logic [31:0] a);
      logic [16:0] s1;
      logic [15:0] s2;
      s1 = {1'b0, a[15:0]} + {1'b0, a[31:16]};
      s2 = s1[15:0] + {15'd0, s1[16]};
      return s2;
   endfunction

`ifdef TCP_PSEUDO_CSUM_EN
   // Word idx of a TCP header, MSB-first; indices past the end read as 0.
   function automatic logic [15:0] tcp_word(input logic [TCP_W-1:0] hdr,
                                            input logic [CNT_W-1:0] idx);
      logic [TCP_W-1:0] sh;
      sh = hdr << {idx, 4'b0000};
      return sh[TCP_W-1 -: 16];
   endfunction
`endif

   state_t              state_q, state_d;
   logic [IP_W-1:0]     ip_hdr_q, ip_hdr_d;
   logic [TCP_W-1:0]    tcp_hdr_q, tcp_hdr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [31:0]         acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                val_q, val_d;
   logic                rdy_q, rdy_d;
`ifdef TCP_PSEUDO_CSUM_EN
   logic [31:0]         tcp_acc_q, tcp_acc_d;
   logic [15:0]         tcp_partial_q, tcp_partial_d;
   logic [15:0]         tcp_len_s;
   logic [31:0]         pseudo_sum_s;

   // Pseudo-header sum taken straight from the incoming IP header.
   always_comb begin
      tcp_len_s    = tcp_chksum_tx_ip_header[IP_W-17 -: 16] - 16'(`IP_HEADER_BYTES);
      pseudo_sum_s = {16'd0, tcp_chksum_tx_ip_header[IP_W-97  -: 16]}
                   + {16'd0, tcp_chksum_tx_ip_header[IP_W-113 -: 16]}
                   + {16'd0, tcp_chksum_tx_ip_header[IP_W-129 -: 16]}
                   + {16'd0, tcp_chksum_tx_ip_header[IP_W-145 -: 16]}
                   + 32'h0000_0006
                   + {16'd0, tcp_len_s};
   end
`endif

   // Next-state and datapath logic for the accept / sum / fold / output sequence.
   always_comb begin
      state_d   = state_q;
      ip_hdr_d  = ip_hdr_q;
      tcp_hdr_d = tcp_hdr_q;
      addr_d    = addr_q;
      len_d     = len_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      val_d     = val_q;
      rdy_d     = rdy_q;
`ifdef TCP_PSEUDO_CSUM_EN
      tcp_acc_d     = tcp_acc_q;
      tcp_partial_d = tcp_partial_q;
`endif
      case (state_q)
         S_IDLE: begin
            val_d = 1'b0;
            rdy_d = 1'b1;
            if (tcp_chksum_tx_val && rdy_q) begin
               ip_hdr_d = tcp_chksum_tx_ip_header;
               ip_hdr_d[IP_CSUM_LSB +: 16] = 16'h0000;
               tcp_hdr_d = tcp_chksum_tx_tcp_header;
               addr_d    = tcp_chksum_tx_payload_addr;
               len_d     = tcp_chksum_tx_payload_len;
               acc_d     = 32'd0;
               cnt_d     = {CNT_W{1'b0}};
               rdy_d     = 1'b0;
               state_d   = S_SUM;
`ifdef TCP_PSEUDO_CSUM_EN
               tcp_acc_d = pseudo_sum_s;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SUM: begin
            rdy_d = 1'b0;
            acc_d = acc_q + {16'd0, ip_word(ip_hdr_q, cnt_q)};
`ifdef TCP_PSEUDO_CSUM_EN
            tcp_acc_d = tcp_acc_q + {16'd0, tcp_word(tcp_hdr_q, cnt_q)};
`endif
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N_SUM - 1)) begin
               state_d = S_FOLD;
            end else begin
               state_d = S_SUM;
            end
         end
         S_FOLD: begin
            rdy_d = 1'b0;
            ip_hdr_d[IP_CSUM_LSB +: 16] = ~fold16(acc_q);
`ifdef TCP_PSEUDO_CSUM_EN
            tcp_partial_d = fold16(tcp_acc_q);
`endif
            val_d   = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (val_q && parser_chksum_tx_rdy) begin
               val_d   = 1'b0;
               rdy_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               val_d   = 1'b1;
               rdy_d   = 1'b0;
               state_d = S_OUT;
            end
         end
         default: begin
            val_d   = 1'b0;
            rdy_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any header in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ip_hdr_q  <= {IP_W{1'b0}};
         tcp_hdr_q <= {TCP_W{1'b0}};
         addr_q    <= {ADDR_W{1'b0}};
         len_q     <= {LEN_W{1'b0}};
         acc_q     <= 32'd0;
         cnt_q     <= {CNT_W{1'b0}};
         val_q     <= 1'b0;
         rdy_q     <= 1'b0;
`ifdef TCP_PSEUDO_CSUM_EN
         tcp_acc_q     <= 32'd0;
         tcp_partial_q <= 16'd0;
`endif
      end else begin
         state_q   <= state_d;
         ip_hdr_q  <= ip_hdr_d;
         tcp_hdr_q <= tcp_hdr_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         val_q     <= val_d;
         rdy_q     <= rdy_d;
`ifdef TCP_PSEUDO_CSUM_EN
         tcp_acc_q     <= tcp_acc_d;
         tcp_partial_q <= tcp_partial_d;
`endif
      end
   end

   assign chksum_tcp_tx_rdy             = rdy_q;
   assign chksum_parser_tx_val          = val_q;
   assign chksum_parser_tx_ip_header    = ip_hdr_q;
   assign chksum_parser_tx_tcp_header   = tcp_hdr_q;
   assign chksum_parser_tx_payload_addr = addr_q;
   assign chksum_parser_tx_payload_len  = len_q;
`ifdef TCP_PSEUDO_CSUM_EN
   assign chksum_parser_tx_tcp_partial  = tcp_partial_q;
`endif

endmodule

// File: tb/tb_ip_hdr_chksum_tx.sv
// Testbench for ip_hdr_chksum_tx: directed and random header sets, with a
// scoreboard queue filled by the driver and drained by an output monitor.

`ifndef IP_HEADER_WIDTH
`define IP_HEADER_WIDTH 160
`endif
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif
`ifndef PAYLOAD_BUF_ENTRY_ADDR_WIDTH
`define PAYLOAD_BUF_ENTRY_ADDR_WIDTH 32
`endif
`ifndef PAYLOAD_BUF_ENTRY_LEN_WIDTH
`define PAYLOAD_BUF_ENTRY_LEN_WIDTH 16
`endif
`ifndef IP_HEADER_BYTES
`define IP_HEADER_BYTES 20
`endif

module tb_ip_hdr_chksum_tx;

   localparam int IPW  = `IP_HEADER_WIDTH;
   localparam int TCPW = `TCP_HEADER_WIDTH;
   localparam int AW   = `PAYLOAD_BUF_ENTRY_ADDR_WIDTH;
   localparam int LW   = `PAYLOAD_BUF_ENTRY_LEN_WIDTH;
   localparam int NIP  = IPW / 16;
   localparam int NTCP = TCPW / 16;
`ifdef TCP_PSEUDO_CSUM_EN
   localparam int NSUM = (NIP > NTCP) ? NIP : NTCP;
`else
   localparam int NSUM = NIP;
`endif
   localparam int LAT  = NSUM + 1;
   localparam int CW   = 256;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_val = 1'b0;
   logic            in_rdy;
   logic [IPW-1:0]  in_ip = '0;
   logic [TCPW-1:0] in_tcp = '0;
   logic [AW-1:0]   in_addr = '0;
   logic [LW-1:0]   in_len = '0;
   logic            out_val;
   logic            prdy = 1'b1;
   logic [IPW-1:0]  out_ip;
   logic [TCPW-1:0] out_tcp;
   logic [AW-1:0]   out_addr;
   logic [LW-1:0]   out_len;
   logic [15:0]     out_partial;

   ip_hdr_chksum_tx dut (
      .clk                           (clk),
      .rst                           (rst),
      .tcp_chksum_tx_val             (in_val),
      .chksum_tcp_tx_rdy             (in_rdy),
      .tcp_chksum_tx_ip_header       (in_ip),
      .tcp_chksum_tx_tcp_header      (in_tcp),
      .tcp_chksum_tx_payload_addr    (in_addr),
      .tcp_chksum_tx_payload_len     (in_len),
      .chksum_parser_tx_val          (out_val),
      .parser_chksum_tx_rdy          (prdy),
      .chksum_parser_tx_ip_header    (out_ip),
      .chksum_parser_tx_tcp_header   (out_tcp),
      .chksum_parser_tx_payload_addr (out_addr),
      .chksum_parser_tx_payload_len  (out_len)
`ifdef TCP_PSEUDO_CSUM_EN
     ,.chksum_parser_tx_tcp_partial  (out_partial)
`endif
   );

`ifndef TCP_PSEUDO_CSUM_EN
   assign out_partial = 16'h0000;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [IPW-1:0]  ip;
      logic [TCPW-1:0] tcp;
      logic [AW-1:0]   addr;
      logic [LW-1:0]   len;
      logic [15:0]     partial;
      int              acc_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   stall_cnt = 0;
   bit   rand_bp = 1'b0;

   // monitor state
   bit              prev_val = 1'b0;
   bit              prev_stall = 1'b0;
   bit              after_xfer = 1'b0;
   logic [IPW-1:0]  snap_ip;
   logic [TCPW-1:0] snap_tcp;
   logic [AW-1:0]   snap_addr;
   logic [LW-1:0]   snap_len;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: repeated end-around carry until the sum fits in 16 bits.
   function automatic logic [15:0] fold_sum(input longint s);
      longint t;
      t = s;
      while ((t >> 16) != 0) t = (t & 64'hFFFF) + (t >> 16);
      return 16'(t);
   endfunction

   function automatic logic [15:0] hword_ip(input logic [IPW-1:0] h, input int k);
      return h[IPW-1-16*k -: 16];
   endfunction

   function automatic logic [15:0] hword_tcp(input logic [TCPW-1:0] h, input int k);
      return h[TCPW-1-16*k -: 16];
   endfunction

   // IPv4 header checksum: complement of the one's-complement sum of every
   // header word except the checksum word itself.
   function automatic logic [15:0] model_ip_csum(input logic [IPW-1:0] ip);
      longint s;
      s = 0;
      for (int k = 0; k < NIP; k++) if (k != 5) s += longint'(hword_ip(ip, k));
      return ~fold_sum(s);
   endfunction

   // TCP partial: pseudo-header (src, dst, proto 6, TCP length) plus TCP header words.
   function automatic logic [15:0] model_tcp_partial(input logic [IPW-1:0] ip, input logic [TCPW-1:0] tcp);
      longint s;
      longint tl;
      tl = (longint'(hword_ip(ip, 1)) - `IP_HEADER_BYTES) & 64'hFFFF;
      s = longint'(hword_ip(ip, 6)) + longint'(hword_ip(ip, 7))
        + longint'(hword_ip(ip, 8)) + longint'(hword_ip(ip, 9)) + 6 + tl;
      for (int k = 0; k < NTCP; k++) s += longint'(hword_tcp(tcp, k));
      return fold_sum(s);
   endfunction

   function automatic logic [IPW-1:0] rand_ip();
      logic [IPW-1:0] h;
      for (int k = 0; k < NIP; k++) h[IPW-1-16*k -: 16] = 16'($urandom);
      return h;
   endfunction

   function automatic logic [TCPW-1:0] rand_tcp();
      logic [TCPW-1:0] h;
      for (int k = 0; k < NTCP; k++) h[TCPW-1-16*k -: 16] = 16'($urandom);
      return h;
   endfunction

   // Offer one header set; push the expected result on accept when push=1.
   // use_csum selects a fixed expected checksum instead of the model value.
   task automatic send(input logic [IPW-1:0] ip, input logic [TCPW-1:0] tcp,
                       input logic [AW-1:0] addr, input logic [LW-1:0] len,
                       input bit push, input bit use_csum, input logic [15:0] csum);
      exp_t e;
      int   w;
      w = 0;
      @(negedge clk);
      while (!in_rdy && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_rdy) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: rdy still %0b after %0d cycles", in_rdy, w);
         return;
      end
      e.ip   = ip;
      e.ip[IPW-81 -: 16] = use_csum ? csum : model_ip_csum(ip);
      e.tcp  = tcp;
      e.addr = addr;
      e.len  = len;
`ifdef TCP_PSEUDO_CSUM_EN
      e.partial = model_tcp_partial(ip, tcp);
`else
      e.partial = 16'h0000;
`endif
      in_ip   = ip;
      in_tcp  = tcp;
      in_addr = addr;
      in_len  = len;
      in_val  = 1'b1;
      @(posedge clk);
      #1;
      in_val    = 1'b0;
      e.acc_cyc = cyc;
      if (push) sb_q.push_back(e);
      // scramble inputs so any output still tied to them is exposed
      in_ip   = rand_ip();
      in_tcp  = rand_tcp();
      in_addr = AW'($urandom);
      in_len  = LW'($urandom);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("drain_queue_empty", CW'(sb_q.size()), CW'(0));
      repeat (2) @(negedge clk);
   endtask

   // Downstream ready: forced stalls, random backpressure, or always ready.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stall_cnt > 0) begin
            prdy = 1'b0;
            if (out_val) stall_cnt--;
         end else if (rand_bp) begin
            prdy = ($urandom_range(0, 3) != 0);
         end else begin
            prdy = 1'b1;
         end
      end
   end

   // Output monitor: latency, hold-under-stall, scoreboard compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_val   = 1'b0;
            prev_stall = 1'b0;
            after_xfer = 1'b0;
         end else begin
            if (after_xfer) begin
               chk("rdy_after_xfer", CW'(in_rdy), CW'(1));
               after_xfer = 1'b0;
            end
            if (prev_stall) begin
               chk("val_held", CW'(out_val), CW'(1));
               chk("hold_ip", CW'(out_ip), CW'(snap_ip));
               chk("hold_tcp", CW'(out_tcp), CW'(snap_tcp));
               chk("hold_addr", CW'(out_addr), CW'(snap_addr));
               chk("hold_len", CW'(out_len), CW'(snap_len));
            end
            if (out_val && !prev_val) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_val: val=1 with no header expected (t=%0t)", $time);
               end else begin
                  chk("latency", CW'(cyc - sb_q[0].acc_cyc), CW'(LAT));
               end
            end
            if (out_val && !prdy) begin
               if (!prev_stall) begin
                  snap_ip   = out_ip;
                  snap_tcp  = out_tcp;
                  snap_addr = out_addr;
                  snap_len  = out_len;
               end
               chk("rdy_low_in_out", CW'(in_rdy), CW'(0));
               prev_stall = 1'b1;
            end else begin
               prev_stall = 1'b0;
            end
            if (out_val && prdy) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_xfer: transfer with empty scoreboard (t=%0t)", $time);
               end else begin
                  e = sb_q.pop_front();
                  chk("ip_header", CW'(out_ip), CW'(e.ip));
                  chk("tcp_header", CW'(out_tcp), CW'(e.tcp));
                  chk("payload_addr", CW'(out_addr), CW'(e.addr));
                  chk("payload_len", CW'(out_len), CW'(e.len));
`ifdef TCP_PSEUDO_CSUM_EN
                  chk("tcp_partial", CW'(out_partial), CW'(e.partial));
`endif
                  after_xfer = 1'b1;
               end
            end
            prev_val = out_val;
         end
      end
   end

   // Main stimulus sequence.
   initial begin
      logic [IPW-1:0]  ip_ref;
      logic [IPW-1:0]  ip_tmp;
      logic [TCPW-1:0] tcp_ref;

      ip_ref  = {16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                 16'h0000, 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
      tcp_ref = {16'h1234, 16'h5678, 128'h0};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_rdy", CW'(in_rdy), CW'(0));
      chk("rst_val", CW'(out_val), CW'(0));
      chk("rst_ip", CW'(out_ip), CW'(0));
      chk("rst_tcp", CW'(out_tcp), CW'(0));
      chk("rst_addr", CW'(out_addr), CW'(0));
      chk("rst_len", CW'(out_len), CW'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst", CW'(in_rdy), CW'(1));

      // known checksum vector
      send(ip_ref, tcp_ref, AW'(32'h0000_1000), LW'(16'd64), 1'b1, 1'b1, 16'hB861);
      drain();

      // input checksum field ignored
      ip_tmp = ip_ref;
      ip_tmp[IPW-81 -: 16] = 16'hFFFF;
      send(ip_tmp, tcp_ref, AW'(32'h0000_2000), LW'(16'd0), 1'b1, 1'b1, 16'hB861);
      drain();

      // word sum 0x1FFFF exercises the carry of the first fold
      ip_tmp = {16'hFFFF, 16'hFFFF, 16'h0001, 112'h0};
      send(ip_tmp, rand_tcp(), AW'($urandom), LW'($urandom), 1'b1, 1'b1, 16'hFFFE);
      drain();

      // backpressure: downstream stalls for 20 output cycles
      stall_cnt = 20;
      send(rand_ip(), rand_tcp(), AW'($urandom), LW'($urandom), 1'b1, 1'b0, 16'h0000);
      drain();

      // reset while word 4 is being summed drops the header
      send(rand_ip(), rand_tcp(), AW'($urandom), LW'($urandom), 1'b0, 1'b0, 16'h0000);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midsum_rst_val", CW'(out_val), CW'(0));
      chk("midsum_rst_rdy", CW'(in_rdy), CW'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("midsum_rdy_back", CW'(in_rdy), CW'(1));
      repeat (NSUM + 4) @(negedge clk);
      chk("midsum_no_val", CW'(out_val), CW'(0));
      send(ip_ref, tcp_ref, AW'(32'h0000_3000), LW'(16'd12), 1'b1, 1'b1, 16'hB861);
      drain();

`ifdef TCP_PSEUDO_CSUM_EN
      // pseudo-header partial sum
      ip_tmp = {16'h4500, 16'h0030, 16'h0000, 16'h4000, 16'h4006,
                16'h0000, 16'h0a00, 16'h0001, 16'h0a00, 16'h0002};
      send(ip_tmp, tcp_ref, AW'(32'h0000_4000), LW'(16'd8), 1'b1, 1'b0, 16'h0000);
      drain();
`endif

      // random headers with random downstream backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send(rand_ip(), rand_tcp(), AW'($urandom),
              ($urandom_range(0, 7) == 0) ? LW'(0) : LW'($urandom),
              1'b1, 1'b0, 16'h0000);
      end
      drain();
      rand_bp = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
